// File: rtl/life_generation_engine.sv
// life_generation_engine: paced, loadable, single-steppable 16x16 B3/S23 Game of Life grid.
module life_generation_engine #(
    parameter int TICK_DIV = 25000000,
    parameter int WRAP     = 1
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               load_en,
    input  logic [3:0]         load_row,
    input  logic [15:0]        load_data,
    input  logic               run,
    input  logic               step,
    input  logic               clear,
    output logic [15:0][15:0]  grid,
    output logic               gen_strobe,
    output logic [15:0]        generation,
    output logic [8:0]         alive_count,
    output logic               stable
);
    localparam int TW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;
    localparam logic [TW-1:0] TICK_MAX = TW'(TICK_DIV - 1);

    function automatic logic [15:0][15:0] next_gen(input logic [15:0][15:0] g);
        logic [3:0] n;
        int ri, ci;
        next_gen = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++) begin
                n = '0;
                for (int dr = -1; dr <= 1; dr++)
                    for (int dc = -1; dc <= 1; dc++) begin
                        ri = r + dr;
                        ci = c + dc;
                        // Out-of-range indices fold mod 16 when wrapping, otherwise read as dead
                        if ((dr != 0 || dc != 0) && (WRAP != 0 || (ri >= 0 && ri < 16 && ci >= 0 && ci < 16)))
                            n = n + 4'(g[4'(ri)][4'(ci)]);
                    end
                next_gen[r][c] = (n == 4'd3) || (g[r][c] && n == 4'd2);
            end
    endfunction

    function automatic logic [8:0] popcount(input logic [15:0][15:0] g);
        popcount = '0;
        for (int r = 0; r < 16; r++)
            for (int c = 0; c < 16; c++)
                popcount = popcount + 9'(g[r][c]);
    endfunction

    logic [15:0][15:0] nxt;
    logic [TW-1:0]     tick;
    logic              load, adv;

    assign nxt  = next_gen(grid);
    assign load = load_en && !run && !clear;
    assign adv  = !clear && !load && (run ? tick == TICK_MAX : step);

    always_ff @(posedge Clock) begin
        if (Reset) begin
            grid        <= '0;
            generation  <= '0;
            tick        <= '0;
            gen_strobe  <= 1'b0;
            alive_count <= '0;
            stable      <= 1'b1;
        end else begin
            gen_strobe  <= adv;
            alive_count <= popcount(grid);
            stable      <= nxt == grid;
            // A dropped run discards the partial interval
            tick        <= (clear || !run || tick == TICK_MAX) ? '0 : tick + 1'b1;
            if (clear) begin
                grid       <= '0;
                generation <= '0;
            end else if (load) begin
                grid[load_row] <= load_data;
                generation     <= '0;
            end else if (adv) begin
                grid       <= nxt;
                generation <= generation + 16'd1;
            end
        end
    end
endmodule

// File: tb/tb_life_generation_engine.sv
// tb_life_generation_engine: directed checks of stepping, pacing, edges and priority.
module tb_life_generation_engine;
    logic Clock = 0;
    logic Reset, load_en, run, step, clear;
    logic [3:0] load_row;
    logic [15:0] load_data;
    logic [15:0][15:0] grid, grid0, exp, exp0;
    logic gen_strobe, gen_strobe0, stable, stable0;
    logic [15:0] generation, generation0;
    logic [8:0] alive_count, alive_count0;
    int checks = 0;
    int errors = 0;

    always #5 Clock = ~Clock;

    life_generation_engine #(.TICK_DIV(4), .WRAP(1)) dut (
        .Clock(Clock), .Reset(Reset), .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .run(run), .step(step), .clear(clear), .grid(grid), .gen_strobe(gen_strobe),
        .generation(generation), .alive_count(alive_count), .stable(stable));

    life_generation_engine #(.TICK_DIV(4), .WRAP(0)) dut0 (
        .Clock(Clock), .Reset(Reset), .load_en(load_en), .load_row(load_row), .load_data(load_data),
        .run(run), .step(step), .clear(clear), .grid(grid0), .gen_strobe(gen_strobe0),
        .generation(generation0), .alive_count(alive_count0), .stable(stable0));

    task automatic cyc();
        @(posedge Clock);
        #1;
    endtask

    task automatic do_clear();
        clear = 1;
        cyc();
        clear = 0;
    endtask

    task automatic do_load(input logic [3:0] row, input logic [15:0] data);
        load_en = 1;
        load_row = row;
        load_data = data;
        cyc();
        load_en = 0;
    endtask

    task automatic do_step();
        step = 1;
        cyc();
        step = 0;
    endtask

    task automatic test_reset();
        Reset = 1;
        cyc();
        cyc();
        Reset = 0;
        checks++; if (grid !== '0) begin errors++; $display("FAIL reset_grid got %h exp 0", grid); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL reset_generation got %0d exp 0", generation); end
        checks++; if (alive_count !== 9'd0) begin errors++; $display("FAIL reset_alive got %0d exp 0", alive_count); end
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL reset_stable got %b exp 1", stable); end
        checks++; if (gen_strobe !== 1'b0) begin errors++; $display("FAIL reset_strobe got %b exp 0", gen_strobe); end
    endtask

    task automatic test_blinker();
        do_clear();
        do_load(4'd7, 16'h01C0);
        do_step();
        exp = '0;
        exp[6] = 16'h0080; exp[7] = 16'h0080; exp[8] = 16'h0080;
        checks++; if (grid !== exp) begin errors++; $display("FAIL blinker_step1_grid got %h exp %h", grid, exp); end
        checks++; if (generation !== 16'd1) begin errors++; $display("FAIL blinker_gen1 got %0d exp 1", generation); end
        checks++; if (gen_strobe !== 1'b1) begin errors++; $display("FAIL blinker_strobe got %b exp 1", gen_strobe); end
        cyc();
        checks++; if (alive_count !== 9'd3) begin errors++; $display("FAIL blinker_alive got %0d exp 3", alive_count); end
        checks++; if (stable !== 1'b0) begin errors++; $display("FAIL blinker_stable got %b exp 0", stable); end
        checks++; if (gen_strobe !== 1'b0) begin errors++; $display("FAIL blinker_strobe_end got %b exp 0", gen_strobe); end
        do_step();
        exp = '0;
        exp[7] = 16'h01C0;
        checks++; if (grid !== exp) begin errors++; $display("FAIL blinker_step2_grid got %h exp %h", grid, exp); end
        checks++; if (generation !== 16'd2) begin errors++; $display("FAIL blinker_gen2 got %0d exp 2", generation); end
    endtask

    task automatic test_still_life();
        do_clear();
        do_load(4'd4, 16'h0030);
        do_load(4'd5, 16'h0030);
        do_step();
        exp = '0;
        exp[4] = 16'h0030; exp[5] = 16'h0030;
        checks++; if (grid !== exp) begin errors++; $display("FAIL still_grid got %h exp %h", grid, exp); end
        checks++; if (generation !== 16'd1) begin errors++; $display("FAIL still_gen got %0d exp 1", generation); end
        cyc();
        checks++; if (stable !== 1'b1) begin errors++; $display("FAIL still_stable got %b exp 1", stable); end
        checks++; if (alive_count !== 9'd4) begin errors++; $display("FAIL still_alive got %0d exp 4", alive_count); end
    endtask

    task automatic test_edges();
        do_clear();
        do_load(4'd0, 16'h0007);
        do_step();
        exp = '0;
        exp[15] = 16'h0002; exp[0] = 16'h0002; exp[1] = 16'h0002;
        exp0 = '0;
        exp0[0] = 16'h0002; exp0[1] = 16'h0002;
        checks++; if (grid !== exp) begin errors++; $display("FAIL wrap1_grid got %h exp %h", grid, exp); end
        checks++; if (grid0 !== exp0) begin errors++; $display("FAIL wrap0_grid got %h exp %h", grid0, exp0); end
        cyc();
        checks++; if (alive_count !== 9'd3) begin errors++; $display("FAIL wrap1_alive got %0d exp 3", alive_count); end
        checks++; if (alive_count0 !== 9'd2) begin errors++; $display("FAIL wrap0_alive got %0d exp 2", alive_count0); end
    endtask

    task automatic test_run_pacing();
        int strobes = 0;
        int first = 0;
        do_clear();
        do_load(4'd7, 16'h01C0);
        run = 1;
        for (int i = 1; i <= 12; i++) begin
            cyc();
            if (gen_strobe) strobes++;
            checks++; if (gen_strobe !== (i % 4 == 0)) begin errors++; $display("FAIL run_strobe_cycle%0d got %b exp %b", i, gen_strobe, i % 4 == 0); end
        end
        checks++; if (strobes != 3) begin errors++; $display("FAIL run_strobe_count got %0d exp 3", strobes); end
        checks++; if (generation !== 16'd3) begin errors++; $display("FAIL run_gen got %0d exp 3", generation); end
        cyc();
        cyc();
        run = 0;
        cyc();
        checks++; if (generation !== 16'd3) begin errors++; $display("FAIL run_drop_gen got %0d exp 3", generation); end
        run = 1;
        for (int i = 1; i <= 8 && first == 0; i++) begin
            cyc();
            if (gen_strobe) first = i;
        end
        checks++; if (first != 4) begin errors++; $display("FAIL run_reraise_latency got %0d exp 4", first); end
        run = 0;
        cyc();
    endtask

    task automatic test_priority();
        do_clear();
        do_load(4'd7, 16'h01C0);
        do_step();
        clear = 1; load_en = 1; load_row = 4'd3; load_data = 16'hFFFF; step = 1;
        cyc();
        clear = 0; load_en = 0; step = 0;
        checks++; if (grid !== '0) begin errors++; $display("FAIL prio_grid got %h exp 0", grid); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL prio_gen got %0d exp 0", generation); end
        checks++; if (gen_strobe !== 1'b0) begin errors++; $display("FAIL prio_strobe got %b exp 0", gen_strobe); end
        do_load(4'd7, 16'h01C0);
        exp = '0;
        exp[7] = 16'h01C0;
        run = 1; load_en = 1; load_row = 4'd0; load_data = 16'hFFFF; step = 1;
        for (int i = 0; i < 2; i++) begin
            cyc();
            checks++; if (gen_strobe !== 1'b0) begin errors++; $display("FAIL prio_run_strobe got %b exp 0", gen_strobe); end
        end
        run = 0; load_en = 0; step = 0;
        checks++; if (grid !== exp) begin errors++; $display("FAIL prio_run_grid got %h exp %h", grid, exp); end
        checks++; if (generation !== 16'd0) begin errors++; $display("FAIL prio_run_gen got %0d exp 0", generation); end
    endtask

    task automatic test_back_to_back();
        do_clear();
        do_load(4'd7, 16'h01C0);
        step = 1;
        cyc();
        checks++; if (generation !== 16'd1) begin errors++; $display("FAIL b2b_gen1 got %0d exp 1", generation); end
        cyc();
        step = 0;
        checks++; if (generation !== 16'd2) begin errors++; $display("FAIL b2b_gen2 got %0d exp 2", generation); end
        checks++; if (gen_strobe !== 1'b1) begin errors++; $display("FAIL b2b_strobe got %b exp 1", gen_strobe); end
        exp = '0;
        exp[7] = 16'h01C0;
        checks++; if (grid !== exp) begin errors++; $display("FAIL b2b_grid got %h exp %h", grid, exp); end
    endtask

    initial begin
        Reset = 1; load_en = 0; load_row = 0; load_data = 0; run = 0; step = 0; clear = 0;
        test_reset();
        test_blinker();
        test_still_life();
        test_edges();
        test_run_pacing();
        test_priority();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
